// File: rtl/denoise_pkg.sv
// Shared constants, FIFO entry layout and FSM encoding for the denoise
// output controller.
package denoise_pkg;

  localparam int IMG_WIDTH  = 752;
  localparam int IMG_HEIGHT = 480;
  localparam int DATA_W     = 8;
  localparam int FIFO_AW    = 10;

  // FIFO entry is {tuser, tlast, data}; positions follow the pixel width.
  function automatic int tlast_bit(input int dw);
    return dw;
  endfunction

  function automatic int tuser_bit(input int dw);
    return dw + 1;
  endfunction

  localparam int TLAST_BIT = DATA_W;
  localparam int TUSER_BIT = DATA_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with a registered first-word-fall-through output stage.
// Occupancy counts the output register, so full/level cover every held word.
module sync_fifo_fwft #(
  parameter int WIDTH = 10,
  parameter int AW    = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_level
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_mcnt;
  logic             r_ovld;
  logic [WIDTH-1:0] r_dout;

  logic [AW:0] w_level;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_load;

  assign w_level = r_mcnt + {{AW{1'b0}}, r_ovld};
  assign w_full  = (w_level == (AW+1)'(DEPTH));
  // A full FIFO refuses writes even when a read happens in the same cycle.
  assign w_push  = i_wr_en && !w_full;
  assign w_pop   = r_ovld && i_rd_en;
  assign w_load  = (r_mcnt != '0) && (!r_ovld || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_mcnt <= '0;
      r_ovld <= 1'b0;
      r_dout <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_load) begin
        r_rptr <= r_rptr + AW'(1);
        r_dout <= r_mem[r_rptr];
        r_ovld <= 1'b1;
      end else if (w_pop) begin
        r_ovld <= 1'b0;
      end
      r_mcnt <= r_mcnt + (AW+1)'(w_push) - (AW+1)'(w_load);
    end
  end

  assign o_rd_data = r_dout;
  assign o_empty   = !r_ovld;
  assign o_full    = w_full;
  assign o_level   = w_level;

endmodule

// File: rtl/denoise_out_ctrl.sv
// Tags denoise-core pixel bursts with SOF/EOL, queues them and streams them
// out as an AXI4-Stream video master with frame/row length checking.
module denoise_out_ctrl
  import denoise_pkg::*;
#(
  parameter int IMG_WIDTH  = denoise_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = denoise_pkg::IMG_HEIGHT,
  parameter int DATA_W     = denoise_pkg::DATA_W,
  parameter int FIFO_AW    = denoise_pkg::FIFO_AW
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              frame_begin,
  input  logic              denoise_valid,
  input  logic [DATA_W-1:0] denoise_dout,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              frame_done,
  output logic              ovf_err,
  output logic              len_err,
  input  logic              err_clr
);

  localparam int COL_W   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FW      = DATA_W + 2;
  localparam int TUSER_B = tuser_bit(DATA_W);
  localparam int TLAST_B = tlast_bit(DATA_W);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_sof_pend;
  logic             r_row_done;
  logic             r_vld_d;
  logic             r_fb_pend;
  logic             r_ovf_err;
  logic             r_len_err;
  logic             r_frame_done;

  logic             w_col_last;
  logic             w_row_last;
  logic             w_fb_idle;
  logic             w_restart;
  logic             w_accept;
  logic             w_overlong;
  logic             w_flush_px;
  logic             w_short;
  logic             w_len_set;
  logic             w_ovf_set;
  logic             w_pop;
  logic             w_last_pop;
  logic [FW-1:0]    w_entry;
  logic [FW-1:0]    w_rd_data;
  logic             w_empty;
  logic             w_full;
  logic [FIFO_AW:0] w_level;

  assign w_col_last = (r_col == COL_W'(IMG_WIDTH - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_HEIGHT - 1));
  assign w_fb_idle  = frame_begin || r_fb_pend;
  assign w_restart  = (r_state == ST_ACTIVE) && frame_begin;

  // A pixel coinciding with frame_begin is not taken; the frame starts after it.
  assign w_accept   = (r_state == ST_ACTIVE) && !frame_begin && denoise_valid && !r_row_done;
  assign w_overlong = (r_state == ST_ACTIVE) && !frame_begin && denoise_valid && r_row_done;
  assign w_flush_px = (r_state == ST_FLUSH) && denoise_valid;
  assign w_short    = (r_state == ST_ACTIVE) && !frame_begin && r_vld_d && !denoise_valid
                      && (r_col != '0);

  assign w_len_set  = (w_restart && ((r_row != '0) || (r_col != '0)))
                      || w_overlong || w_flush_px || w_short;
  assign w_ovf_set  = w_accept && w_full;

  assign w_pop      = !w_empty && m_axis_tready;
  // No pushes happen in FLUSH, so the last-of-frame pixel is the last word out.
  assign w_last_pop = (r_state == ST_FLUSH)
                      && ((w_pop && (w_level == (FIFO_AW+1)'(1))) || (w_level == '0));

  always_comb begin
    w_entry                = '0;
    w_entry[DATA_W-1:0]    = denoise_dout;
    w_entry[TUSER_B]       = r_sof_pend;
    w_entry[TLAST_B]       = w_col_last;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_fb_idle) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_accept && w_col_last && w_row_last) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_last_pop) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_col      <= '0;
      r_row      <= '0;
      r_sof_pend <= 1'b0;
      r_row_done <= 1'b0;
      r_vld_d    <= 1'b0;
      r_fb_pend  <= 1'b0;
    end else begin
      r_vld_d   <= denoise_valid;
      r_fb_pend <= (r_state == ST_FLUSH) ? (r_fb_pend || frame_begin) : 1'b0;
      if (!denoise_valid) begin
        r_row_done <= 1'b0;
      end
      if (((r_state == ST_IDLE) && w_fb_idle) || w_restart) begin
        r_col      <= '0;
        r_row      <= '0;
        r_sof_pend <= 1'b1;
        r_row_done <= 1'b0;
      end else if (w_accept) begin
        r_sof_pend <= 1'b0;
        if (w_col_last) begin
          // Remaining pixels of this burst are overlong and get dropped.
          r_col      <= '0;
          r_row      <= w_row_last ? '0 : (r_row + ROW_W'(1));
          r_row_done <= 1'b1;
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end else if (w_short) begin
        r_col <= '0;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_ovf_err    <= 1'b0;
      r_len_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_ovf_err    <= w_ovf_set | (r_ovf_err & ~err_clr);
      r_len_err    <= w_len_set | (r_len_err & ~err_clr);
      r_frame_done <= w_last_pop;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (FW),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk     (s_axi_aclk),
    .i_rst_n   (s_axi_aresetn),
    .i_wr_en   (w_accept),
    .i_wr_data (w_entry),
    .i_rd_en   (m_axis_tready),
    .o_rd_data (w_rd_data),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_level   (w_level)
  );

  assign m_axis_tdata  = w_rd_data[DATA_W-1:0];
  assign m_axis_tuser  = w_rd_data[TUSER_B];
  assign m_axis_tlast  = w_rd_data[TLAST_B];
  assign m_axis_tvalid = !w_empty;
  assign fifo_level    = w_level;
  assign frame_done    = r_frame_done;
  assign ovf_err       = r_ovf_err;
  assign len_err       = r_len_err;

endmodule
